load_store_unit: RTL and testbench

Memory-stage load/store unit sitting directly upstream of the byte-addressed data memory. It accepts one load or store request per cycle from the EX/MEM pipeline register and drives the memory's address, byte-write-enable, write-data and read-enable inputs. Every load reads as an aligned word. Loads that straddle a word boundary are split into two aligned reads under a small FSM. The block performs byte/halfword extraction and sign/zero extension and returns a registered load result tagged with the destination register.

---
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: drives a byte-addressed data memory, splits
// word-straddling loads into two aligned reads and returns extended load data.
module load_store_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_WriteData,
    output logic [3:0]      mem_WriteEnable,
    output logic [1:0]      mem_load_type,
    output logic            mem_MemRead,
    input  logic [XLEN-1:0] mem_ReadData
);

    typedef enum logic {
        IDLE,
        SECOND
    } state_t;

    state_t          state;
    logic [XLEN-1:2] base_q;
    logic [1:0]      off_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] word0;

    logic            accept;
    logic            load_ok;
    logic            load_split;
    logic [3:0]      store_mask;

    // Shift the two-word window down by the byte offset, then size and extend.
    function automatic logic [XLEN-1:0] extract(
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic [1:0]      off,
        input logic [2:0]      f3
    );
        logic [XLEN-1:0] win;
        win = XLEN'({hi, lo} >> {off, 3'b000});
        case (f3)
            3'b000:  return {{(XLEN-8){win[7]}}, win[7:0]};
            3'b001:  return {{(XLEN-16){win[15]}}, win[15:0]};
            3'b010:  return win;
            3'b100:  return {{(XLEN-8){1'b0}}, win[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, win[15:0]};
            default: return '0;
        endcase
    endfunction

    assign req_ready     = (state == IDLE);
    assign accept        = req_valid && req_ready;
    assign mem_load_type = 2'b10;

    always_comb begin
        load_ok    = 1'b0;
        store_mask = '0;
        case (req_funct3)
            3'b000: begin
                load_ok    = 1'b1;
                store_mask = 4'b0001;
            end
            3'b001: begin
                load_ok    = 1'b1;
                store_mask = 4'b0011;
            end
            3'b010: begin
                load_ok    = 1'b1;
                store_mask = 4'b1111;
            end
            3'b100, 3'b101: load_ok = 1'b1;
            default: ;
        endcase
    end

    // Halfwords only straddle at offset 3; words straddle at any non-zero offset.
    assign load_split = ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                        ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));

    always_comb begin
        mem_address     = '0;
        mem_WriteData   = '0;
        mem_WriteEnable = '0;
        mem_MemRead     = 1'b0;
        if (state == SECOND) begin
            mem_MemRead = 1'b1;
            mem_address = {base_q + (XLEN-2)'(1), 2'b00};
        end else if (req_valid) begin
            if (req_is_store) begin
                mem_address     = req_addr;
                mem_WriteData   = req_wdata;
                mem_WriteEnable = store_mask;
            end else if (load_ok) begin
                mem_MemRead = 1'b1;
                mem_address = {req_addr[XLEN-1:2], 2'b00};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            base_q     <= '0;
            off_q      <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            word0      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !req_is_store) begin
                        base_q   <= req_addr[XLEN-1:2];
                        off_q    <= req_addr[1:0];
                        funct3_q <= req_funct3;
                        rd_q     <= req_rd;
                        word0    <= mem_ReadData;
                        if (load_split) begin
                            state <= SECOND;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_data  <= extract('0, mem_ReadData, req_addr[1:0], req_funct3);
                            resp_rd    <= req_rd;
                        end
                    end
                end
                SECOND: begin
                    state      <= IDLE;
                    resp_valid <= 1'b1;
                    resp_data  <= extract(mem_ReadData, word0, off_q, funct3_q);
                    resp_rd    <= rd_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, byte-level reference model,
// directed scenarios followed by randomized requests.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic [31:0] mem_address;
    logic [31:0] mem_WriteData;
    logic [3:0]  mem_WriteEnable;
    logic [1:0]  mem_load_type;
    logic        mem_MemRead;
    logic [31:0] mem_ReadData;

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .mem_address(mem_address), .mem_WriteData(mem_WriteData),
        .mem_WriteEnable(mem_WriteEnable), .mem_load_type(mem_load_type),
        .mem_MemRead(mem_MemRead), .mem_ReadData(mem_ReadData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory seen by the DUT; addresses alias modulo 256
    logic [7:0] dmem [256] = '{default: 8'h00};
    always_comb
        mem_ReadData = {dmem[mem_address[7:0] + 8'd3], dmem[mem_address[7:0] + 8'd2],
                        dmem[mem_address[7:0] + 8'd1], dmem[mem_address[7:0]]};
    always @(posedge clk) begin
        if (mem_WriteEnable[0]) dmem[mem_address[7:0]]        <= mem_WriteData[7:0];
        if (mem_WriteEnable[1]) dmem[mem_address[7:0] + 8'd1] <= mem_WriteData[15:8];
        if (mem_WriteEnable[2]) dmem[mem_address[7:0] + 8'd2] <= mem_WriteData[23:16];
        if (mem_WriteEnable[3]) dmem[mem_address[7:0] + 8'd3] <= mem_WriteData[31:24];
    end

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    exp_t        expq[$];
    int          busy = -1;
    logic [31:0] sec_addr = '0;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bit load_valid(input logic [2:0] f);
        return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b101);
    endfunction

    function automatic int nbytes(input logic [2:0] f);
        return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] exp_we(input logic [2:0] f);
        case (f)
            3'b000:  return 4'b0001;
            3'b001:  return 4'b0011;
            3'b010:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
        logic [31:0] v;
        logic [31:0] ai;
        v = '0;
        for (int i = 0; i < nbytes(f); i++) begin
            ai = a + 32'(i);
            v[8*i +: 8] = ref_mem[ai[7:0]];
        end
        if (f == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
        if (f == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic model_accept(input bit st, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] wd, input logic [4:0] rd,
                                input bit use_lit, input logic [31:0] lit);
        exp_t        e;
        logic [31:0] ai;
        if (st) begin
            if (exp_we(f) != 4'b0000)
                for (int i = 0; i < nbytes(f); i++) begin
                    ai = a + 32'(i);
                    ref_mem[ai[7:0]] = wd[8*i +: 8];
                end
        end else begin
            e.rd  = rd;
            e.due = cyc + 1;
            e.data = '0;
            if (load_valid(f)) begin
                e.data = model_load(f, a);
                if (int'(a[1:0]) + nbytes(f) > 4) begin
                    e.due    = cyc + 2;
                    busy     = cyc + 1;
                    sec_addr = (a & 32'hFFFF_FFFC) + 32'd4;
                end
            end
            expq.push_back(e);
            if (use_lit) chk("model_literal", e.data, lit);
        end
    endtask

    task automatic issue(input bit st, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input bit use_lit, input logic [31:0] lit);
        int waits;
        waits        = 0;
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
        forever begin
            @(negedge clk); #1;
            if (req_ready) break;
            waits++;
            if (waits > 4) begin
                n_checks++;
                n_err++;
                $display("FAIL ready_timeout: req_ready stuck at %b, required 1", req_ready);
                break;
            end
            @(posedge clk); #1;
        end
        if (req_ready) model_accept(st, f, a, wd, rd, use_lit, lit);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Per-cycle compare of every DUT output against the model
    always @(negedge clk) begin
        chk("req_ready", req_ready, (cyc != busy));
        chk("load_type", mem_load_type, 2'b10);
        if (expq.size() > 0 && expq[0].due == cyc) begin
            chk("resp_valid", resp_valid, 1'b1);
            chk("resp_data", resp_data, expq[0].data);
            chk("resp_rd", resp_rd, expq[0].rd);
            void'(expq.pop_front());
        end else begin
            chk("resp_valid_low", resp_valid, 1'b0);
        end
        if (cyc == busy) begin
            chk("second_read", mem_MemRead, 1'b1);
            chk("second_addr", mem_address, sec_addr);
            chk("second_we", mem_WriteEnable, 4'b0000);
        end else if (req_valid && !reset) begin
            if (req_is_store) begin
                chk("st_we", mem_WriteEnable, exp_we(req_funct3));
                chk("st_read", mem_MemRead, 1'b0);
                if (exp_we(req_funct3) != 4'b0000) begin
                    chk("st_addr", mem_address, req_addr);
                    chk("st_wdata", mem_WriteData, req_wdata);
                end
            end else begin
                chk("ld_we", mem_WriteEnable, 4'b0000);
                chk("ld_read", mem_MemRead, load_valid(req_funct3));
                if (load_valid(req_funct3))
                    chk("ld_addr", mem_address, req_addr & 32'hFFFF_FFFC);
            end
        end else begin
            chk("idle_addr", mem_address, 32'h0);
            chk("idle_wdata", mem_WriteData, 32'h0);
            chk("idle_we", mem_WriteEnable, 4'b0000);
            chk("idle_read", mem_MemRead, 1'b0);
        end
    end

    task automatic reset_checks();
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_rd", resp_rd, 5'd0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_mem_read", mem_MemRead, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [2:0] vtab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bit         r_st;
    logic [2:0] r_f;
    logic [31:0] r_a;
    int         r;

    initial begin
        @(negedge clk); #1;
        reset_checks();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        issue(1, 3'b010, 32'h10, 32'h11223344, 5'd0, 0, 0);
        issue(0, 3'b010, 32'h10, 32'h0, 5'd7, 1, 32'h11223344);
        issue(0, 3'b000, 32'h13, 32'h0, 5'd8, 1, 32'h00000011);
        issue(1, 3'b000, 32'h14, 32'h80, 5'd0, 0, 0);
        issue(0, 3'b000, 32'h14, 32'h0, 5'd9, 1, 32'hFFFFFF80);
        issue(0, 3'b100, 32'h14, 32'h0, 5'd10, 1, 32'h00000080);
        issue(0, 3'b101, 32'h13, 32'h0, 5'd11, 1, 32'h00008011);
        issue(0, 3'b001, 32'h13, 32'h0, 5'd12, 1, 32'hFFFF8011);
        issue(1, 3'b010, 32'h14, 32'h55667788, 5'd0, 0, 0);
        issue(0, 3'b010, 32'h12, 32'h0, 5'd13, 1, 32'h77881122);

        // Reset while the second read of a split load is in flight
        issue(0, 3'b001, 32'h13, 32'h0, 5'd14, 0, 0);
        #1;
        reset = 1'b1;
        expq.delete();
        busy = -1;
        @(negedge clk); #1;
        reset_checks();
        @(posedge clk); #1;
        reset = 1'b0;
        issue(0, 3'b010, 32'h10, 32'h0, 5'd15, 1, 32'h11223344);

        issue(0, 3'b010, 32'h10, 32'h0, 5'd1, 1, 32'h11223344);
        issue(0, 3'b010, 32'h14, 32'h0, 5'd2, 1, 32'h55667788);
        issue(0, 3'b000, 32'h12, 32'h0, 5'd3, 1, 32'h00000022);
        issue(0, 3'b101, 32'h16, 32'h0, 5'd4, 1, 32'h00005566);

        issue(1, 3'b010, 32'hFFFFFFFC, 32'hAABBCCDD, 5'd0, 0, 0);
        issue(1, 3'b010, 32'h00000000, 32'h01020304, 5'd0, 0, 0);
        issue(0, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd5, 1, 32'h0304AABB);

        issue(0, 3'b011, 32'h10, 32'h0, 5'd6, 1, 32'h0);
        issue(1, 3'b110, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0);
        issue(1, 3'b001, 32'h11, 32'h0000BEEF, 5'd0, 0, 0);
        issue(0, 3'b010, 32'h10, 32'h0, 5'd16, 1, 32'h11BEEF44);

        for (int n = 0; n < 400; n++) begin
            r_st = ($urandom_range(0, 9) < 4);
            r = $urandom_range(0, 19);
            if (r < 18) r_f = vtab[r % 5];
            else        r_f = (r == 18) ? 3'b011 : 3'b111;
            if ($urandom_range(0, 3) == 0) r_a = 32'hFFFFFFC0 + 32'($urandom_range(0, 63));
            else                           r_a = 32'($urandom_range(0, 63));
            issue(r_st, r_f, r_a, $urandom, 5'($urandom_range(0, 31)), 0, 0);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk); #1;
                end
        end

        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("drain_pending", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
